// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants for the RAM port arbiter: arbitration mode encodings and
// the helper that sizes per-port index fields.
package ram_port_arbiter_pkg;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Width of a port index; never below 1 so index fields stay legal vectors.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_picker.sv
// Circular priority picker: first requester at or after start wins (one-hot).
// Fixed priority is the special case start == 0.
module round_robin_picker
  import ram_port_arbiter_pkg::*;
#(
  parameter  int unsigned NUM_PORTS = 2,
  localparam int unsigned IdxW      = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IdxW-1:0]      start,
  output logic [NUM_PORTS-1:0] grant
);

  logic        found;
  int unsigned p;

  always_comb begin
    found = 1'b0;
    grant = '0;
    p     = 0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      p = (32'(start) + i) % NUM_PORTS;
      if (!found && req[p]) begin
        grant[p] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Multi-port arbiter in front of a single-port RAM: combinational grant with
// optional lock, fixed or round-robin priority, and read-tag return pipeline.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS     = 2,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 17,
  parameter int unsigned RD_LATENCY    = 1,
  parameter int unsigned ARB_MODE      = ARB_FIXED
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [NUM_PORTS-1:0]             we,
  input  logic [NUM_PORTS-1:0]             lock,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  wdata,
  output logic [NUM_PORTS-1:0]             grant,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic [NUM_PORTS-1:0]             rvalid,
  output logic                             ram_CE,
  output logic                             ram_WE,
  output logic [ADDRESS_WIDTH-1:0]         ram_address,
  output logic [DATA_WIDTH-1:0]            ram_data_output,
  input  logic [DATA_WIDTH-1:0]            ram_data_input
);

  localparam int unsigned IdxW = idx_width(NUM_PORTS);

  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic                  locked_q, locked_d;
  logic                  held;
  logic [IdxW-1:0]       start;
  logic [NUM_PORTS-1:0]  pick;
  logic [IdxW-1:0]       gidx;
  logic                  gany;
  logic                  rd_issue;

  logic [RD_LATENCY-1:0] tag_v_q;
  logic [IdxW-1:0]       tag_idx_q [RD_LATENCY];

  // A held lock overrides arbitration; a dropped lock falls straight through.
  assign held  = locked_q && req[owner_q] && lock[owner_q];
  assign start = (ARB_MODE == ARB_RR) ? ptr_q : '0;

  round_robin_picker #(
    .NUM_PORTS (NUM_PORTS)
  ) u_picker (
    .req   (req),
    .start (start),
    .grant (pick)
  );

  always_comb begin
    grant = '0;
    gidx  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      grant[i] = rst && (held ? (owner_q == IdxW'(i)) : pick[i]);
    end
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) gidx = IdxW'(i);
    end
  end

  assign gany = |grant;

  always_comb begin
    ram_CE          = 1'b0;
    ram_WE          = 1'b0;
    ram_address     = '0;
    ram_data_output = '0;
    if (gany) begin
      ram_CE          = 1'b1;
      ram_WE          = we[gidx];
      ram_address     = addr[32'(gidx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      ram_data_output = wdata[32'(gidx)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign rd_issue = ram_CE && !ram_WE;

  always_comb begin
    ptr_d    = ptr_q;
    owner_d  = gidx;
    locked_d = gany && lock[gidx];
    if (ARB_MODE == ARB_RR && gany && !held) begin
      ptr_d = (32'(gidx) == NUM_PORTS - 1) ? '0 : gidx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q    <= '0;
      owner_q  <= '0;
      locked_q <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_v_q <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) tag_idx_q[i] <= '0;
    end else begin
      tag_v_q[0]   <= rd_issue;
      tag_idx_q[0] <= gidx;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        tag_v_q[i]   <= tag_v_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (tag_v_q[RD_LATENCY-1]) begin
      rvalid[tag_idx_q[RD_LATENCY-1]] = 1'b1;
      rdata                           = ram_data_input;
    end
  end

endmodule
